moment_ram_arbiter: RTL and testbench
=====================================

MOMENT_RAM_ARBITER -- requirements
Module: moment_ram_arbiter

Interface
REQ-001: The block SHALL have parameter DEPTH, default 256, giving the moment RAM entry count (16x16 lattice).
REQ-002: The block SHALL have parameter ADDRESS_WIDTH, default $clog2(DEPTH) = 8, giving the RAM address width.
REQ-003: The block SHALL have parameter DATA_WIDTH, default 64, giving the moment word width.
REQ-004: The block SHALL have port Clk, input, 1, the single system clock; all state changes on its rising edge.
REQ-005: The block SHALL have port Reset_n, input, 1, asynchronous active-low reset.
REQ-006: The block SHALL have port wr_req, input, 1, the collision-stage write request.
REQ-007: The block SHALL have port wr_addr, input, ADDRESS_WIDTH, the write address.
REQ-008: The block SHALL have port wr_data, input, DATA_WIDTH, the write word.
REQ-009: The block SHALL have port wr_gnt, output, 1, the write accept; wr_req & wr_gnt is one transfer.
REQ-010: The block SHALL have port rd_req, input, 1, the readout-stage read request.
REQ-011: The block SHALL have port rd_addr, input, ADDRESS_WIDTH, the read address.
REQ-012: The block SHALL have port rd_gnt, output, 1, the read accept; rd_req & rd_gnt is one transfer.
REQ-013: The block SHALL have port rd_data, output, DATA_WIDTH, the read word, meaningful only while rd_valid=1.
REQ-014: The block SHALL have port rd_valid, output, 1, which is high for exactly one cycle per read transfer.
REQ-015: The block SHALL have port clear_start, input, 1, a request to re-zero the whole RAM.
REQ-016: The block SHALL have port busy_clear, output, 1, which is high while a clear sweep is in progress.
REQ-017: The block SHALL have ports address (output, ADDRESS_WIDTH), WE (output, 1), data_in (output, DATA_WIDTH) and data_out (input, DATA_WIDTH), which connect to the moment_ram port.

Function
REQ-018: The moment_ram SHALL be a single-port RAM with synchronous write and registered read: data_out reflects the address presented one cycle earlier.
REQ-019: The FSM SHALL have two states: CLEAR and SERVE.
REQ-020: In CLEAR, the block SHALL drive WE=1, address=clr_cnt and data_in=0 each cycle, increment clr_cnt, and keep wr_gnt=rd_gnt=0 and busy_clear=1.
REQ-021: When clr_cnt=DEPTH-1 is written, the FSM SHALL enter SERVE on the next edge and clr_cnt SHALL wrap to 0, so each clear sweep is exactly DEPTH cycles.
REQ-022: In SERVE with only wr_req high, wr_gnt SHALL be asserted combinationally in the same cycle, with WE=1, address=wr_addr and data_in=wr_data.
REQ-023: In SERVE with only rd_req high, rd_gnt SHALL be asserted combinationally in the same cycle, with WE=0 and address=rd_addr.
REQ-024: With both requests high in SERVE, the block SHALL grant round-robin using a 1-bit last_winner flag, granting the requester that did not win the previous contested or uncontested transfer.
REQ-025: last_winner SHALL reset to READ, so the writer wins the first conflict.
REQ-026: At most one grant SHALL be high per cycle, and no grant SHALL be issued without its matching request.
REQ-027: Requesters SHALL hold req, addr and data stable until granted; the block SHALL not queue requests.
REQ-028: rd_valid SHALL be registered high in the cycle after a read transfer, and rd_data SHALL be passed through combinationally from data_out.
REQ-029: A write at cycle N followed by a read of the same address at N+1 SHALL return the new word at N+2.
REQ-030: With no request in SERVE, the block SHALL drive WE=0, address=0 and data_in=0.
REQ-031: clear_start=1 in SERVE SHALL suppress grants in that cycle and move the FSM to CLEAR with clr_cnt=0; any pending request SHALL stay pending.
REQ-032: clear_start SHALL be ignored while in CLEAR.
REQ-033: A read transfer in the last SERVE cycle before CLEAR SHALL still produce rd_valid on the next cycle.

Reset
REQ-034: While Reset_n=0, the block SHALL hold state=CLEAR, clr_cnt=0, last_winner=READ, rd_valid=0, wr_gnt=0, rd_gnt=0, busy_clear=1, and force WE=0, address=0 and data_in=0.
REQ-035: Deassertion of Reset_n SHALL begin a full clear sweep at address 0.
REQ-036: Reset asserted mid-sweep or mid-read SHALL abort the operation, and rd_valid SHALL not be asserted for an aborted read.

Verification
REQ-037: Release reset -> busy_clear=1 for 256 cycles with WE=1, address 0x00..0xFF and data_in=0, then busy_clear=0; reads of 0x00, 0x7F and 0xFF return 0.
REQ-038: Write 0x00 <= 64'h0100_0000_0000_0000, then read 0x00 -> rd_valid=1 one cycle after rd_gnt with rd_data=64'h0100_0000_0000_0000.
REQ-039: Hold wr_req and rd_req high for 4 cycles after reset and clear -> grant sequence W,R,W,R, never both grants in one cycle.
REQ-040: clear_start pulse with rd_req(0x10) pending after writing 0x10=5 -> no rd_gnt for 256 cycles, then rd_gnt and rd_data=0.
REQ-041: Assert Reset_n=0 at clr_cnt=100 for 2 cycles -> after release, the sweep restarts at address 0 and lasts 256 cycles.
REQ-042: Assert reset the cycle after a read transfer -> rd_valid stays 0.

Source files
------------

// File: rtl/moment_ram_arbiter.sv
// -----------------------------------------------------------------------------
// moment_ram_arbiter
//   Shares one single-port moment RAM between the collision stage (writer)
//   and the readout stage (reader). After reset, or on request, the whole RAM
//   is swept to zero before any requester is served.
//
// Ports
//   Clk, Reset_n          : system clock, asynchronous active-low reset
//   wr_req/wr_addr/wr_data: write request; accepted in the cycle wr_gnt=1
//   rd_req/rd_addr        : read request; accepted in the cycle rd_gnt=1
//   rd_data/rd_valid      : read word, valid the cycle after the read grant
//   clear_start           : request a zeroing sweep of the whole RAM
//   busy_clear            : high while the zeroing sweep runs
//   address/WE/data_in    : RAM command (registered-read, synchronous write)
//   data_out              : RAM read word
// -----------------------------------------------------------------------------
module moment_ram_arbiter #(
    parameter int DEPTH         = 256,
    parameter int ADDRESS_WIDTH = $clog2(DEPTH),
    parameter int DATA_WIDTH    = 64
) (
    input  logic                     Clk,
    input  logic                     Reset_n,
    input  logic                     wr_req,
    input  logic [ADDRESS_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0]    wr_data,
    output logic                     wr_gnt,
    input  logic                     rd_req,
    input  logic [ADDRESS_WIDTH-1:0] rd_addr,
    output logic                     rd_gnt,
    output logic [DATA_WIDTH-1:0]    rd_data,
    output logic                     rd_valid,
    input  logic                     clear_start,
    output logic                     busy_clear,
    output logic [ADDRESS_WIDTH-1:0] address,
    output logic                     WE,
    output logic [DATA_WIDTH-1:0]    data_in,
    input  logic [DATA_WIDTH-1:0]    data_out
);

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_SERVE = 1'b1
    } state_t;

    // Identity of the side that won the most recent transfer.
    localparam logic WIN_WRITE = 1'b0;
    localparam logic WIN_READ  = 1'b1;

    localparam logic [ADDRESS_WIDTH-1:0] LAST_ADDR = ADDRESS_WIDTH'(DEPTH - 1);

    state_t                     state_r;
    state_t                     state_next_s;
    logic [ADDRESS_WIDTH-1:0]   clr_cnt_r;
    logic [ADDRESS_WIDTH-1:0]   clr_cnt_next_s;
    logic                       last_winner_r;
    logic                       last_winner_next_s;
    logic                       rd_valid_r;

    logic                       wr_gnt_s;
    logic                       rd_gnt_s;
    logic                       we_s;
    logic [ADDRESS_WIDTH-1:0]   addr_s;
    logic [DATA_WIDTH-1:0]      din_s;
    logic                       busy_s;

    // State, sweep counter, arbitration history and read-valid registers.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_r       <= ST_CLEAR;
            clr_cnt_r     <= '0;
            last_winner_r <= WIN_READ;
            rd_valid_r    <= 1'b0;
        end else begin
            state_r       <= state_next_s;
            clr_cnt_r     <= clr_cnt_next_s;
            last_winner_r <= last_winner_next_s;
            rd_valid_r    <= rd_gnt_s;
        end
    end

    // Next-state, grant and RAM command decode.
    always_comb begin
        state_next_s       = state_r;
        clr_cnt_next_s     = clr_cnt_r;
        last_winner_next_s = last_winner_r;
        wr_gnt_s           = 1'b0;
        rd_gnt_s           = 1'b0;
        we_s               = 1'b0;
        addr_s             = '0;
        din_s              = '0;
        busy_s             = 1'b0;
        case (state_r)
            ST_CLEAR: begin
                // clear_start has no effect here: the sweep simply runs on.
                busy_s = 1'b1;
                we_s   = 1'b1;
                addr_s = clr_cnt_r;
                if (clr_cnt_r == LAST_ADDR) begin
                    state_next_s   = ST_SERVE;
                    clr_cnt_next_s = '0;
                end else begin
                    clr_cnt_next_s = clr_cnt_r + ADDRESS_WIDTH'(1);
                end
            end
            ST_SERVE: begin
                if (clear_start) begin
                    // Grants withheld; requesters keep requesting through the sweep.
                    state_next_s   = ST_CLEAR;
                    clr_cnt_next_s = '0;
                end else if (wr_req && (!rd_req || (last_winner_r == WIN_READ))) begin
                    wr_gnt_s           = 1'b1;
                    we_s               = 1'b1;
                    addr_s             = wr_addr;
                    din_s              = wr_data;
                    last_winner_next_s = WIN_WRITE;
                end else if (rd_req) begin
                    rd_gnt_s           = 1'b1;
                    addr_s             = rd_addr;
                    last_winner_next_s = WIN_READ;
                end else begin
                    addr_s = '0;
                end
            end
            default: begin
                state_next_s   = ST_CLEAR;
                clr_cnt_next_s = '0;
                busy_s         = 1'b1;
            end
        endcase
    end

    assign wr_gnt     = wr_gnt_s;
    assign rd_gnt     = rd_gnt_s;
    assign busy_clear = busy_s;
    assign rd_valid   = rd_valid_r;
    assign rd_data    = data_out;

    // The RAM must see an idle command while reset is held, even though the
    // state register already sits at the start of a sweep.
    assign WE      = we_s & Reset_n;
    assign address = Reset_n ? addr_s : '0;
    assign data_in = Reset_n ? din_s  : '0;

endmodule

// File: tb/tb_moment_ram_arbiter.sv
// -----------------------------------------------------------------------------
// tb_moment_ram_arbiter
//   Directed bench for moment_ram_arbiter with a behavioural registered-read
//   RAM attached. Inputs change and outputs are sampled in the low clock phase.
// -----------------------------------------------------------------------------
module tb_moment_ram_arbiter;

    localparam logic [63:0] ARB_WORD = 64'hA5A5_0000_1234_5678;
    localparam logic [63:0] WR_WORD  = 64'h0100_0000_0000_0000;

    logic        Clk;
    logic        Reset_n;
    logic        wr_req;
    logic [7:0]  wr_addr;
    logic [63:0] wr_data;
    logic        wr_gnt;
    logic        rd_req;
    logic [7:0]  rd_addr;
    logic        rd_gnt;
    logic [63:0] rd_data;
    logic        rd_valid;
    logic        clear_start;
    logic        busy_clear;
    logic [7:0]  address;
    logic        WE;
    logic [63:0] data_in;
    logic [63:0] data_out;

    logic [63:0] mem [256];

    int total;
    int bad;

    moment_ram_arbiter dut (
        .Clk(Clk), .Reset_n(Reset_n),
        .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_gnt(wr_gnt),
        .rd_req(rd_req), .rd_addr(rd_addr), .rd_gnt(rd_gnt),
        .rd_data(rd_data), .rd_valid(rd_valid),
        .clear_start(clear_start), .busy_clear(busy_clear),
        .address(address), .WE(WE), .data_in(data_in), .data_out(data_out)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Behavioural moment RAM: synchronous write, registered read.
    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 64'hDEAD_BEEF_0000_0000 | 64'(i);
        data_out = 64'h0;
    end
    always @(posedge Clk) begin
        if (WE) mem[address] <= data_in;
        data_out <= mem[address];
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, want finish before it");
        $fatal(1, "watchdog");
    end

    task automatic test_reset;
        repeat (3) @(negedge Clk);
        wr_req = 1'b1; rd_req = 1'b1; clear_start = 1'b1;
        #1;
        total++;
        if (busy_clear !== 1'b1 || WE !== 1'b0 || address !== 8'h00 || data_in !== 64'h0 ||
            wr_gnt !== 1'b0 || rd_gnt !== 1'b0 || rd_valid !== 1'b0) begin
            bad++;
            $display("FAIL reset_state: busy=%b we=%b addr=%h din=%h wg=%b rg=%b rv=%b, want 1 0 00 0 0 0 0",
                     busy_clear, WE, address, data_in, wr_gnt, rd_gnt, rd_valid);
        end
        wr_req = 1'b0; rd_req = 1'b0; clear_start = 1'b0;
        @(negedge Clk);
        Reset_n = 1'b1;
        #1;
        for (int i = 0; i < 256; i++) begin
            total++;
            if (busy_clear !== 1'b1 || WE !== 1'b1 || address !== 8'(i) || data_in !== 64'h0) begin
                bad++;
                $display("FAIL reset_sweep_%0d: busy=%b we=%b addr=%h din=%h, want busy=1 we=1 addr=%h din=0",
                         i, busy_clear, WE, address, data_in, 8'(i));
            end
            @(negedge Clk); #1;
        end
        total++;
        if (busy_clear !== 1'b0) begin
            bad++;
            $display("FAIL reset_sweep_end: busy=%b, want 0", busy_clear);
        end
    endtask

    task automatic test_arbitration;
        logic exp_w;
        wr_req = 1'b1; wr_addr = 8'h20; wr_data = ARB_WORD;
        rd_req = 1'b1; rd_addr = 8'h30;
        for (int k = 0; k < 4; k++) begin
            #1;
            exp_w = (k % 2 == 0);
            total++;
            if (wr_gnt !== exp_w || rd_gnt !== !exp_w) begin
                bad++;
                $display("FAIL arb_cycle_%0d: wr_gnt=%b rd_gnt=%b, want wr_gnt=%b rd_gnt=%b",
                         k, wr_gnt, rd_gnt, exp_w, !exp_w);
            end
            total++;
            if (rd_valid !== (k == 2)) begin
                bad++;
                $display("FAIL arb_valid_%0d: rd_valid=%b, want %b", k, rd_valid, (k == 2));
            end
            @(negedge Clk);
        end
        wr_req = 1'b0; rd_req = 1'b0;
        #1;
        total++;
        if (rd_valid !== 1'b1 || rd_data !== 64'h0) begin
            bad++;
            $display("FAIL arb_last_read: rd_valid=%b rd_data=%h, want 1 0", rd_valid, rd_data);
        end
        total++;
        if (WE !== 1'b0 || address !== 8'h00 || data_in !== 64'h0 || wr_gnt !== 1'b0 || rd_gnt !== 1'b0) begin
            bad++;
            $display("FAIL idle_cmd: we=%b addr=%h din=%h wg=%b rg=%b, want all 0",
                     WE, address, data_in, wr_gnt, rd_gnt);
        end
    endtask

    task automatic test_read_zero;
        logic [7:0] addrs [3];
        addrs[0] = 8'h00; addrs[1] = 8'h7F; addrs[2] = 8'hFF;
        for (int j = 0; j < 3; j++) begin
            @(negedge Clk);
            rd_req = 1'b1; rd_addr = addrs[j];
            #1;
            total++;
            if (rd_gnt !== 1'b1 || WE !== 1'b0 || address !== addrs[j]) begin
                bad++;
                $display("FAIL rdzero_gnt_%h: rd_gnt=%b we=%b addr=%h, want 1 0 %h",
                         addrs[j], rd_gnt, WE, address, addrs[j]);
            end
            @(negedge Clk);
            rd_req = 1'b0;
            #1;
            total++;
            if (rd_valid !== 1'b1 || rd_data !== 64'h0) begin
                bad++;
                $display("FAIL rdzero_data_%h: rd_valid=%b rd_data=%h, want 1 0",
                         addrs[j], rd_valid, rd_data);
            end
        end
    endtask

    task automatic test_write_read;
        @(negedge Clk);
        wr_req = 1'b1; wr_addr = 8'h00; wr_data = WR_WORD;
        #1;
        total++;
        if (wr_gnt !== 1'b1 || rd_gnt !== 1'b0 || WE !== 1'b1 || address !== 8'h00 || data_in !== WR_WORD) begin
            bad++;
            $display("FAIL wr_cmd: wg=%b rg=%b we=%b addr=%h din=%h, want 1 0 1 00 %h",
                     wr_gnt, rd_gnt, WE, address, data_in, WR_WORD);
        end
        @(negedge Clk);
        wr_req = 1'b0; rd_req = 1'b1; rd_addr = 8'h00;
        #1;
        total++;
        if (rd_gnt !== 1'b1 || rd_valid !== 1'b0) begin
            bad++;
            $display("FAIL wr_then_rd_gnt: rd_gnt=%b rd_valid=%b, want 1 0", rd_gnt, rd_valid);
        end
        @(negedge Clk);
        rd_req = 1'b0;
        #1;
        total++;
        if (rd_valid !== 1'b1 || rd_data !== WR_WORD) begin
            bad++;
            $display("FAIL wr_then_rd_data: rd_valid=%b rd_data=%h, want 1 %h", rd_valid, rd_data, WR_WORD);
        end
        @(negedge Clk); #1;
        total++;
        if (rd_valid !== 1'b0) begin
            bad++;
            $display("FAIL rd_valid_one_cycle: rd_valid=%b, want 0", rd_valid);
        end
    endtask

    task automatic test_read_before_clear_and_reset_mid_sweep;
        @(negedge Clk);
        rd_req = 1'b1; rd_addr = 8'h20;
        #1;
        total++;
        if (rd_gnt !== 1'b1) begin
            bad++;
            $display("FAIL last_read_gnt: rd_gnt=%b, want 1", rd_gnt);
        end
        @(negedge Clk);
        rd_req = 1'b0; clear_start = 1'b1;
        #1;
        total++;
        if (rd_valid !== 1'b1 || rd_data !== ARB_WORD || rd_gnt !== 1'b0) begin
            bad++;
            $display("FAIL last_read_valid: rv=%b rd_data=%h rg=%b, want 1 %h 0",
                     rd_valid, rd_data, rd_gnt, ARB_WORD);
        end
        @(negedge Clk);
        clear_start = 1'b0;
        #1;
        for (int i = 0; i <= 100; i++) begin
            total++;
            if (busy_clear !== 1'b1 || address !== 8'(i) || WE !== 1'b1) begin
                bad++;
                $display("FAIL presweep_%0d: busy=%b we=%b addr=%h, want 1 1 %h",
                         i, busy_clear, WE, address, 8'(i));
            end
            if (i < 100) begin
                @(negedge Clk); #1;
            end
        end
        Reset_n = 1'b0;
        #1;
        total++;
        if (WE !== 1'b0 || address !== 8'h00 || busy_clear !== 1'b1) begin
            bad++;
            $display("FAIL midsweep_reset: we=%b addr=%h busy=%b, want 0 00 1", WE, address, busy_clear);
        end
        @(negedge Clk);
        @(negedge Clk);
        Reset_n = 1'b1;
        #1;
        for (int i = 0; i < 256; i++) begin
            total++;
            if (busy_clear !== 1'b1 || WE !== 1'b1 || address !== 8'(i) || data_in !== 64'h0) begin
                bad++;
                $display("FAIL resweep_%0d: busy=%b we=%b addr=%h din=%h, want 1 1 %h 0",
                         i, busy_clear, WE, address, data_in, 8'(i));
            end
            @(negedge Clk); #1;
        end
        total++;
        if (busy_clear !== 1'b0) begin
            bad++;
            $display("FAIL resweep_end: busy=%b, want 0", busy_clear);
        end
    endtask

    task automatic test_clear_pending;
        @(negedge Clk);
        wr_req = 1'b1; wr_addr = 8'h10; wr_data = 64'd5;
        #1;
        total++;
        if (wr_gnt !== 1'b1) begin
            bad++;
            $display("FAIL clr_wr_gnt: wr_gnt=%b, want 1", wr_gnt);
        end
        @(negedge Clk);
        wr_req = 1'b0; rd_req = 1'b1; rd_addr = 8'h10; clear_start = 1'b1;
        #1;
        total++;
        if (rd_gnt !== 1'b0 || wr_gnt !== 1'b0 || WE !== 1'b0) begin
            bad++;
            $display("FAIL clr_start_suppress: rg=%b wg=%b we=%b, want 0 0 0", rd_gnt, wr_gnt, WE);
        end
        @(negedge Clk);
        clear_start = 1'b0;
        #1;
        for (int i = 0; i < 256; i++) begin
            clear_start = (i == 50);
            #1;
            total++;
            if (busy_clear !== 1'b1 || rd_gnt !== 1'b0 || address !== 8'(i) || WE !== 1'b1) begin
                bad++;
                $display("FAIL clr_sweep_%0d: busy=%b rg=%b we=%b addr=%h, want 1 0 1 %h",
                         i, busy_clear, rd_gnt, WE, address, 8'(i));
            end
            @(negedge Clk);
        end
        clear_start = 1'b0;
        #1;
        total++;
        if (busy_clear !== 1'b0 || rd_gnt !== 1'b1 || address !== 8'h10) begin
            bad++;
            $display("FAIL clr_pending_gnt: busy=%b rg=%b addr=%h, want 0 1 10", busy_clear, rd_gnt, address);
        end
        @(negedge Clk);
        rd_req = 1'b0;
        #1;
        total++;
        if (rd_valid !== 1'b1 || rd_data !== 64'h0) begin
            bad++;
            $display("FAIL clr_pending_data: rv=%b rd_data=%h, want 1 0", rd_valid, rd_data);
        end
    endtask

    task automatic test_reset_after_read;
        @(negedge Clk);
        rd_req = 1'b1; rd_addr = 8'h10;
        #1;
        total++;
        if (rd_gnt !== 1'b1) begin
            bad++;
            $display("FAIL abort_rd_gnt: rd_gnt=%b, want 1", rd_gnt);
        end
        Reset_n = 1'b0;
        rd_req = 1'b0;
        @(negedge Clk); #1;
        total++;
        if (rd_valid !== 1'b0) begin
            bad++;
            $display("FAIL abort_rd_valid_in_reset: rd_valid=%b, want 0", rd_valid);
        end
        @(negedge Clk);
        Reset_n = 1'b1;
        #1;
        total++;
        if (rd_valid !== 1'b0 || busy_clear !== 1'b1 || address !== 8'h00 || WE !== 1'b1) begin
            bad++;
            $display("FAIL abort_after_release: rv=%b busy=%b addr=%h we=%b, want 0 1 00 1",
                     rd_valid, busy_clear, address, WE);
        end
    endtask

    initial begin
        total = 0; bad = 0;
        Reset_n = 1'b0;
        wr_req = 1'b0; wr_addr = 8'h00; wr_data = 64'h0;
        rd_req = 1'b0; rd_addr = 8'h00; clear_start = 1'b0;
        test_reset();
        test_arbitration();
        test_read_zero();
        test_write_read();
        test_read_before_clear_and_reset_mid_sweep();
        test_clear_pending();
        test_reset_after_read();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
